// File: rtl/uart_baud_gen.sv
// UART baud-tick generator: rx oversample and tx bit strobes from sys_clk with a run-time divisor.
// Define UART_BAUD_FRAC_EN to build the fractional-divisor accumulators.
module uart_baud_gen #(
   parameter int SYS_CLK    = 30000000,
   parameter int BAUDRATE   = 115200,
   parameter int OVERSAMPLE = 16,
   parameter int DIV_W      = 16,
   parameter int FRAC_W     = 4,
   parameter int DEF_DIV    = SYS_CLK / (BAUDRATE * OVERSAMPLE)
) (
   input  logic              sys_clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              div_load,
   input  logic [DIV_W-1:0]  div_int,
   input  logic [FRAC_W-1:0] div_frac,
   input  logic              rx_resync,
   output logic              rx_clk_en,
   output logic              tx_clk_en,
   output logic              rx_clk,
   output logic              tx_clk,
   output logic              cfg_err
);
   localparam int               CNT_W   = $clog2(OVERSAMPLE);
   localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);
   localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
   localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEF_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OVERSAMPLE - 1);

   logic [DIV_W-1:0] act_int_q, act_int_d, sh_int_q, sh_int_d;
   logic [DIV_W-1:0] rx_pre_q, rx_pre_d, tx_pre_q, tx_pre_d;
   logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
   logic             pend_q, pend_d, cfg_err_q, cfg_err_d;
   logic             rx_clk_q, rx_clk_d, tx_clk_q, tx_clk_d;
   logic [DIV_W-1:0] ld_int, eff_int;
   logic             ld_bad, rx_tick, tx_tick, tx_wrap, apply;
   logic             rx_carry, tx_carry;

   // A pending (or same-cycle) load takes effect on the first base tick of either chain, or at once while idle.
   assign ld_bad  = (div_int < DIV_MIN);
   assign ld_int  = ld_bad ? DIV_MIN : div_int;
   assign rx_tick = ~rst & enable & ~rx_resync & (rx_pre_q == '0);
   assign tx_tick = ~rst & enable & (tx_pre_q == '0);
   assign tx_wrap = (tx_cnt_q == CNT_MAX);
   assign apply   = (pend_q | div_load) & (rx_tick | tx_tick | ~enable);
   assign eff_int = apply ? (div_load ? ld_int : sh_int_q) : act_int_q;

   assign rx_clk_en = rx_tick;
   assign tx_clk_en = tx_tick & tx_wrap;
   assign rx_clk    = rx_clk_q;
   assign tx_clk    = tx_clk_q;
   assign cfg_err   = cfg_err_q;

`ifdef UART_BAUD_FRAC_EN
   logic [FRAC_W-1:0] act_frac_q, act_frac_d, sh_frac_q, sh_frac_d, eff_frac;
   logic [FRAC_W-1:0] rx_acc_q, rx_acc_d, tx_acc_q, tx_acc_d;
   logic [FRAC_W:0]   rx_sum, tx_sum;

   always_comb begin
      eff_frac = act_frac_q;
      if (apply) eff_frac = div_load ? div_frac : sh_frac_q;
      act_frac_d = eff_frac;
      sh_frac_d  = div_load ? div_frac : sh_frac_q;
      rx_sum     = {1'b0, rx_acc_q} + {1'b0, eff_frac};
      tx_sum     = {1'b0, tx_acc_q} + {1'b0, eff_frac};
      rx_carry   = rx_tick & rx_sum[FRAC_W];
      tx_carry   = tx_tick & tx_sum[FRAC_W];
      rx_acc_d   = rx_acc_q;
      if (rx_resync) rx_acc_d = '0;
      else if (rx_tick) rx_acc_d = rx_sum[FRAC_W-1:0];
      tx_acc_d   = tx_tick ? tx_sum[FRAC_W-1:0] : tx_acc_q;
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         act_frac_q <= '0;
         sh_frac_q  <= '0;
         rx_acc_q   <= '0;
         tx_acc_q   <= '0;
      end else begin
         act_frac_q <= act_frac_d;
         sh_frac_q  <= sh_frac_d;
         rx_acc_q   <= rx_acc_d;
         tx_acc_q   <= tx_acc_d;
      end
   end
`else
   logic unused_div_frac;
   assign unused_div_frac = ^div_frac;
   assign rx_carry        = 1'b0;
   assign tx_carry        = 1'b0;
`endif

   always_comb begin
      act_int_d = eff_int;
      sh_int_d  = div_load ? ld_int : sh_int_q;
      pend_d    = pend_q;
      if (apply) pend_d = 1'b0;
      else if (div_load) pend_d = 1'b1;
      cfg_err_d = div_load ? ld_bad : cfg_err_q;

      // Resync restarts the rx phase from the active divisor and suppresses any coincident tick.
      rx_pre_d = rx_pre_q;
      if (rx_resync) rx_pre_d = act_int_q - DIV_ONE;
      else if (rx_tick) rx_pre_d = rx_carry ? eff_int : eff_int - DIV_ONE;
      else if (enable) rx_pre_d = rx_pre_q - DIV_ONE;

      tx_pre_d = tx_pre_q;
      if (tx_tick) tx_pre_d = tx_carry ? eff_int : eff_int - DIV_ONE;
      else if (enable) tx_pre_d = tx_pre_q - DIV_ONE;

      tx_cnt_d = tx_cnt_q;
      if (tx_tick) tx_cnt_d = tx_wrap ? '0 : tx_cnt_q + CNT_W'(1);

      rx_clk_d = rx_clk_q ^ rx_clk_en;
      tx_clk_d = tx_clk_q ^ tx_clk_en;
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         act_int_q <= DIV_RST;
         sh_int_q  <= DIV_RST;
         pend_q    <= 1'b0;
         cfg_err_q <= 1'b0;
         rx_pre_q  <= DIV_RST - DIV_ONE;
         tx_pre_q  <= DIV_RST - DIV_ONE;
         tx_cnt_q  <= '0;
         rx_clk_q  <= 1'b0;
         tx_clk_q  <= 1'b0;
      end else begin
         act_int_q <= act_int_d;
         sh_int_q  <= sh_int_d;
         pend_q    <= pend_d;
         cfg_err_q <= cfg_err_d;
         rx_pre_q  <= rx_pre_d;
         tx_pre_q  <= tx_pre_d;
         tx_cnt_q  <= tx_cnt_d;
         rx_clk_q  <= rx_clk_d;
         tx_clk_q  <= tx_clk_d;
      end
   end
endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen: directed steps plus random traffic against a period-level reference model.
module tb_uart_baud_gen;
   localparam int OS  = 16;
   localparam int FR  = 16;
   localparam int DEF = 16;
`ifdef UART_BAUD_FRAC_EN
   localparam int EXP_FRAC16 = 260;
`else
   localparam int EXP_FRAC16 = 256;
`endif

   logic        sys_clk = 1'b0;
   logic        rst, enable, div_load, rx_resync;
   logic [15:0] div_int;
   logic [3:0]  div_frac;
   logic        rx_clk_en, tx_clk_en, rx_clk, tx_clk, cfg_err;

   int total = 0;
   int bad   = 0;

   uart_baud_gen dut (
      .sys_clk   (sys_clk),
      .rst       (rst),
      .enable    (enable),
      .div_load  (div_load),
      .div_int   (div_int),
      .div_frac  (div_frac),
      .rx_resync (rx_resync),
      .rx_clk_en (rx_clk_en),
      .tx_clk_en (tx_clk_en),
      .rx_clk    (rx_clk),
      .tx_clk    (tx_clk),
      .cfg_err   (cfg_err)
   );

   initial forever #5 sys_clk = ~sys_clk;

   // Reference model: cycles left in the current period of each chain, plus strobe counts.
   int m_act, m_actf, m_sh, m_shf;
   bit m_pend, m_err;
   int rx_left, tx_left, rx_acc, tx_acc, tx_n, rx_cnt, tx_cnt;
   bit obs_rx, obs_tx;

   function automatic void m_reset();
      m_act = DEF; m_actf = 0; m_sh = DEF; m_shf = 0; m_pend = 0; m_err = 0;
      rx_left = DEF; tx_left = DEF; rx_acc = 0; tx_acc = 0; tx_n = 0;
      rx_cnt = 0; tx_cnt = 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input bit r, input bit en, input bit ld, input logic [15:0] di,
                      input logic [3:0] df, input bit rs);
      bit rtk, ttk, e_rx, e_tx, app;
      int li, lf, eff, efff, old_act;
      @(negedge sys_clk);
      rst = r; enable = en; div_load = ld; div_int = di; div_frac = df; rx_resync = rs;
      #1;
      rtk = !r && en && rx_left == 1 && !rs;
      ttk = !r && en && tx_left == 1;
      e_rx = rtk;
      e_tx = ttk && tx_n == OS - 1;
      chk("rx_clk_en", {31'd0, rx_clk_en}, {31'd0, e_rx});
      chk("tx_clk_en", {31'd0, tx_clk_en}, {31'd0, e_tx});
      chk("rx_clk", {31'd0, rx_clk}, rx_cnt % 2);
      chk("tx_clk", {31'd0, tx_clk}, tx_cnt % 2);
      chk("cfg_err", {31'd0, cfg_err}, {31'd0, m_err});
      obs_rx = rx_clk_en;
      obs_tx = tx_clk_en;
      if (r) begin
         m_reset();
      end else begin
         li = (di < 2) ? 2 : int'(di);
`ifdef UART_BAUD_FRAC_EN
         lf = int'(df);
`else
         lf = 0;
`endif
         app  = (m_pend || ld) && (rtk || ttk || !en);
         eff  = app ? (ld ? li : m_sh)  : m_act;
         efff = app ? (ld ? lf : m_shf) : m_actf;
         old_act = m_act;
         if (rs) begin
            rx_left = old_act; rx_acc = 0;
         end else if (rtk) begin
            rx_left = eff + (((rx_acc + efff) >= FR) ? 1 : 0);
            rx_acc  = (rx_acc + efff) % FR;
         end else if (en) rx_left--;
         if (ttk) begin
            tx_left = eff + (((tx_acc + efff) >= FR) ? 1 : 0);
            tx_acc  = (tx_acc + efff) % FR;
            tx_n    = (tx_n + 1) % OS;
         end else if (en) tx_left--;
         if (e_rx) rx_cnt++;
         if (e_tx) tx_cnt++;
         if (ld) begin m_sh = li; m_shf = lf; m_err = (di < 2); end
         if (app) begin m_act = eff; m_actf = efff; m_pend = 0; end
         else if (ld) m_pend = 1;
      end
   endtask

   task automatic run_rx(output int n);
      n = 0;
      do begin cyc(0, 1, 0, 16'd0, 4'd0, 0); n++; end while (!obs_rx && n < 1000);
   endtask

   task automatic run_tx(output int n);
      n = 0;
      do begin cyc(0, 1, 0, 16'd0, 4'd0, 0); n++; end while (!obs_tx && n < 5000);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n, sum;
      rst = 1; enable = 0; div_load = 0; div_int = '0; div_frac = '0; rx_resync = 0;
      repeat (2) @(posedge sys_clk);
      m_reset();
      cyc(1, 0, 0, 16'd0, 4'd0, 0);

      // Defaults: rx every 16, tx every 256.
      run_rx(n); chk("first_rx", n, 16); $display("step first_rx: %0d cycles", n);
      run_rx(n); chk("rx_period", n, 16); $display("step rx_period: %0d", n);
      run_tx(n);
      run_tx(n); chk("tx_period", n, 256); $display("step tx_period: %0d", n);

      // Fractional divisor 16 + 4/16.
      cyc(0, 1, 1, 16'd16, 4'd4, 0);
      run_rx(n);
      sum = 0;
      for (int i = 0; i < 16; i++) begin run_rx(n); sum += n; end
      chk("frac_16_periods", sum, EXP_FRAC16); $display("step frac_16_periods: %0d", sum);
      cyc(0, 1, 1, 16'd16, 4'd0, 0);
      run_rx(n);
      run_rx(n);

      // Load 10 with the rx prescaler at 7.
      repeat (8) cyc(0, 1, 0, 16'd0, 4'd0, 0);
      cyc(0, 1, 1, 16'd10, 4'd0, 0);
      run_rx(n); chk("old_period_completes", n + 9, 16); $display("step old_period: %0d", n + 9);
      run_rx(n); chk("new_period_10", n, 10); $display("step new_period: %0d", n);
      run_tx(n);
      run_tx(n); chk("tx_period_160", n, 160); $display("step tx_period_160: %0d", n);

      // Resync with the rx prescaler at 3.
      run_rx(n);
      repeat (6) cyc(0, 1, 0, 16'd0, 4'd0, 0);
      cyc(0, 1, 0, 16'd0, 4'd0, 1);
      run_rx(n); chk("resync_gap", n, 10); $display("step resync_gap: %0d", n);

      // Illegal divisor clamps to 2, then a legal one clears the error.
      cyc(0, 1, 1, 16'd1, 4'd0, 0);
      cyc(0, 1, 0, 16'd0, 4'd0, 0); chk("cfg_err_set", {31'd0, cfg_err}, 1);
      run_rx(n);
      run_rx(n); chk("clamped_period", n, 2); $display("step clamped_period: %0d", n);
      cyc(0, 1, 1, 16'd8, 4'd0, 0);
      cyc(0, 1, 0, 16'd0, 4'd0, 0); chk("cfg_err_clr", {31'd0, cfg_err}, 0);
      run_rx(n);
      run_rx(n); chk("period_8", n, 8); $display("step period_8: %0d", n);

      // Random traffic checked cycle by cycle against the model.
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom % 300) == 0, ($urandom % 8) != 0, ($urandom % 40) == 0,
             16'($urandom_range(0, 20)), 4'($urandom), ($urandom % 50) == 0);
      end
      $display("step random: %0d rx strobes, %0d tx strobes", rx_cnt, tx_cnt);

      // Hold for 5 cycles mid-period, then reset mid-period.
      cyc(0, 1, 1, 16'd16, 4'd0, 0);
      run_rx(n);
      repeat (5) cyc(0, 1, 0, 16'd0, 4'd0, 0);
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, 0, 16'd0, 4'd0, 0); chk("hold_no_rx", {31'd0, obs_rx}, 0);
      end
      run_rx(n); chk("hold_resume", n, 11); $display("step hold_resume: %0d", n);
      repeat (4) cyc(0, 1, 0, 16'd0, 4'd0, 0);
      cyc(1, 1, 0, 16'd0, 4'd0, 0);
      cyc(0, 1, 0, 16'd0, 4'd0, 0);
      chk("rst_rx_clk", {31'd0, rx_clk}, 0);
      chk("rst_cfg_err", {31'd0, cfg_err}, 0);
      run_rx(n); chk("rst_first_rx", n + 1, 16); $display("step rst_first_rx: %0d", n + 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
